rb_rd_stream: RTL and testbench
===============================

Name: rb_rd_stream

Overview:
- Read-side controller for a circular line buffer held in a sync_dp_ram instance; the writer side owns the write port and wr_ptr.
- Compares its own read pointer with the writer's pointer and issues RAM reads.
- Absorbs the RAM's 1-cycle read latency in a 3-entry skid FIFO and presents a valid/ready stream downstream.
- Returns rd_ptr to the writer so the writer can detect full.

Parameters:
- NUMBER_OF_LINES, 16, RAM depth in lines; power of 2, ≥2.
- DATA_WIDTH, 128, line width in bits.
- AW (local), $clog2(NUMBER_OF_LINES), address width.

Ports:
- clk  in  1  single clock; RAM read and write clocks are both tied to it.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all unread and in-flight data.
- wr_ptr  in  AW+1  writer pointer: AW address bits plus a wrap bit.
- rd_ptr  out  AW+1  read (release) pointer returned to the writer.
- level  out  AW+1  wr_ptr − rd_ptr, modulo 2^(AW+1); lines still in RAM.
- ram_r_en  out  1  to RAM r_en.
- ram_addr_r  out  AW  to RAM addr_r; equals rd_ptr[AW-1:0].
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data.
- ram_mem_valid  in  1  from RAM mem_valid; high 1 cycle after ram_r_en.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.

Behaviour:
Reset (synchronous, active-high):
- rd_ptr=0, skid occupancy=0, inflight=0, discard=0.
- out_valid=0, out_data=0, ram_r_en=0 while rst is high.

Core conditions:
- empty = (rd_ptr == wr_ptr). Full (wr_ptr differs from rd_ptr only in the wrap bit) is the writer's concern; the reader treats it as non-empty.
- issue = !empty && (occ + inflight ≤ 2) && !flush && !rst.
  - Depends only on registered state and wr_ptr; there is no combinational path from out_ready to ram_r_en.
- ram_r_en = issue.
- On issue: rd_ptr increments, wrapping naturally at 2^(AW+1), and inflight<=1 next cycle; otherwise inflight<=0.
- A line is released to the writer at the issue edge. The RAM returns the pre-write contents on a same-edge read/write to the same address, so the writer may overwrite that line from the next cycle.

Skid FIFO (3 entries):
- Push on ram_mem_valid && inflight && !discard, capturing ram_rd_data. ram_rd_data is ignored whenever ram_mem_valid is low, because the RAM drives X then.
- Pop on out_valid && out_ready. Simultaneous push and pop leaves occ unchanged.
- out_valid = (occ != 0), registered. out_data = head entry, registered.
- out_data and out_valid hold stable while out_valid && !out_ready.
- The credit rule guarantees no overflow; an overflow is an assertion failure in verification.

Latency and throughput:
- wr_ptr going non-empty in cycle N gives ram_r_en in N, ram_mem_valid in N+1, and out_valid in N+2.
- With out_ready held high: one line per cycle sustained.
- With out_ready low: at most 3 reads are outstanding (occ + inflight ≤ 3), after which issue stops.

Flush (synchronous):
- Next cycle: rd_ptr<=wr_ptr, occ<=0, out_valid<=0, and no issue in the flush cycle.
- If a read is in flight, discard<=1 for one cycle so the returning beat is dropped.
- flush together with rst: reset wins.
- Reset or flush mid-stream: pending beats are lost and no partial output is produced.

Wrap-around:
- ram_addr_r wraps from NUMBER_OF_LINES−1 to 0 and toggles the wrap bit.
- level is correct across the wrap.

Test Plan:
- Reset then wr_ptr=0 → ram_r_en=0 and out_valid=0 for 20 cycles; rd_ptr=0.
- wr_ptr 0→4 at cycle N, out_ready=1 → ram_r_en high at N..N+3 with addr 0,1,2,3; out_valid high at N+2..N+5 with data = RAM lines 0..3; rd_ptr=4; level=0.
- wr_ptr=8, out_ready=0 → exactly 3 reads issued (rd_ptr=3), out_valid=1 with out_data = line 0 held stable. Raise out_ready → lines 0..7 delivered in order with no gap after the first.
- Writer fills 16 lines, wraps, and writes 5 more while the reader drains with ready toggling every other cycle → 21 beats delivered in order; rd_ptr=21 (0x15, wrap bit set, ram_addr_r=5).
- wr_ptr=6 with out_ready=0; pulse flush while a read is in flight → next cycle out_valid=0, rd_ptr=6, level=0, and the in-flight beat never appears. Advance wr_ptr to 7 → only line 6 is delivered.
- Assert rst mid-stream with 2 beats in the skid → next cycle out_valid=0 and rd_ptr=0; no X ever appears on out_data while out_valid=1.

Source files
------------

// File: rtl/rb_rd_stream.sv
// rb_rd_stream: read-side controller for a circular line buffer in a sync_dp_ram.
// It issues RAM reads against the writer's pointer, absorbs the one-cycle read
// latency in a 3-entry skid FIFO and presents a valid/ready stream downstream.
module rb_rd_stream #(
  parameter int unsigned NUMBER_OF_LINES = 16,
  parameter int unsigned DATA_WIDTH      = 128,
  localparam int unsigned AW             = $clog2(NUMBER_OF_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [AW:0]           wr_ptr,
  output logic [AW:0]           rd_ptr,
  output logic [AW:0]           level,
  output logic                  ram_r_en,
  output logic [AW-1:0]         ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_mem_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned OCC_W      = 2;
  localparam int unsigned CREDIT_W   = 3;

  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d, occ_kept_c;
  logic                  inflight_q, inflight_d;
  logic                  discard_q, discard_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] slot_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] slot_d [SKID_DEPTH];
  logic                  empty_c, issue_c, push_c, pop_c;

  // Read credit: issue only when the skid can hold everything already requested.
  always_comb begin
    empty_c = (rd_ptr_q == wr_ptr);
    issue_c = !empty_c
              && ((CREDIT_W'(occ_q) + CREDIT_W'(inflight_q)) <= CREDIT_W'(2))
              && !flush && !rst;
    push_c  = ram_mem_valid && inflight_q && !discard_q;
    pop_c   = out_valid_q && out_ready;
  end

  // Next state: pointer advance, skid shift/push, flush override.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue_c;
    discard_d  = 1'b0;
    slot_d     = slot_q;
    occ_kept_c = occ_q - OCC_W'(pop_c);

    if (pop_c) begin
      slot_d[0] = slot_q[1];
      slot_d[1] = slot_q[2];
    end

    if (push_c) begin
      case (occ_kept_c)
        2'd0:    slot_d[0] = ram_rd_data;
        2'd1:    slot_d[1] = ram_rd_data;
        2'd2:    slot_d[2] = ram_rd_data;
        default: ;
      endcase
    end

    occ_d = occ_kept_c + OCC_W'(push_c);

    if (issue_c) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Flush jumps to the writer's pointer and drops everything pending.
    if (flush) begin
      rd_ptr_d   = wr_ptr;
      occ_d      = '0;
      inflight_d = 1'b0;
      discard_d  = inflight_q;
    end

    out_valid_d = (occ_d != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      discard_q   <= 1'b0;
      out_valid_q <= 1'b0;
      slot_q      <= '{default: '0};
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
    end
  end

  assign rd_ptr     = rd_ptr_q;
  assign level      = wr_ptr - rd_ptr_q;
  assign ram_r_en   = issue_c;
  assign ram_addr_r = rd_ptr_q[AW-1:0];
  assign out_data   = slot_q[0];
  assign out_valid  = out_valid_q;

  // The credit rule must make a push into a full skid impossible.
  skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_c && !flush && (occ_kept_c == 2'd3)));

endmodule

// File: tb/tb_rb_rd_stream.sv
// tb_rb_rd_stream: randomized self-checking bench for rb_rd_stream with a
// behavioural RAM and an in-order line queue as the reference.
module tb_rb_rd_stream;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr, level;
  logic          ram_r_en;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_rd_data = '0;
  logic          ram_mem_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rb_rd_stream #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .level(level), .ram_r_en(ram_r_en), .ram_addr_r(ram_addr_r),
    .ram_rd_data(ram_rd_data), .ram_mem_valid(ram_mem_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Behavioural RAM read port: one-cycle latency, X data when not valid.
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    ram_mem_valid <= ram_r_en;
    ram_rd_data   <= ram_r_en ? mem[ram_addr_r] : 'x;
  end

  // Stream monitor: records delivered beats, X-on-valid and hold violations.
  logic [DW-1:0] got [$];
  int            x_err = 0;
  int            stab_err = 0;
  logic          pv = 1'b0, pr = 1'b0, pblk = 1'b1;
  logic [DW-1:0] pd = '0;
  always @(negedge clk) begin
    if (!rst && out_valid && $isunknown(out_data)) x_err++;
    if (pv && !pr && !pblk && (out_valid !== 1'b1 || out_data !== pd)) stab_err++;
    if (!rst && out_valid && out_ready) got.push_back(out_data);
    pv   = out_valid;
    pr   = out_ready;
    pblk = rst || flush;
    pd   = out_data;
  end

  logic [DW-1:0] ln  [8];
  logic [DW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_ptr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_ptr = '0;
    tick();
    n_cmp++;
    if (ram_r_en !== 1'b0) begin n_bad++; $display("FAIL reset_r_en_in_rst: got %b want 0", ram_r_en); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (ram_r_en !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_idle cyc %0d: r_en %b valid %b want 0 0", i, ram_r_en, out_valid);
      end
    end
    n_cmp++;
    if (rd_ptr !== '0) begin n_bad++; $display("FAIL reset_rd_ptr: got %h want 0", rd_ptr); end
    n_cmp++;
    if (level !== '0) begin n_bad++; $display("FAIL reset_level: got %h want 0", level); end
  endtask

  task automatic test_burst4();
    for (int i = 0; i < 4; i++) begin ln[i] = rnd_line(); mem[i] = ln[i]; end
    out_ready = 1'b1;
    tick();
    wr_ptr = 5'd4;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (ram_r_en !== (k < 4)) begin
        n_bad++; $display("FAIL burst_r_en cyc %0d: got %b want %b", k, ram_r_en, (k < 4));
      end
      if (k < 4) begin
        n_cmp++;
        if (ram_addr_r !== AW'(k)) begin
          n_bad++; $display("FAIL burst_addr cyc %0d: got %0d want %0d", k, ram_addr_r, k);
        end
      end
      n_cmp++;
      if (out_valid !== (k >= 2 && k <= 5)) begin
        n_bad++; $display("FAIL burst_valid cyc %0d: got %b want %b", k, out_valid, (k >= 2 && k <= 5));
      end
      if (k >= 2 && k <= 5) begin
        n_cmp++;
        if (out_data !== ln[k-2]) begin
          n_bad++; $display("FAIL burst_data cyc %0d: got %h want %h", k, out_data, ln[k-2]);
        end
      end
      tick();
    end
    n_cmp++;
    if (rd_ptr !== 5'd4 || level !== '0) begin
      n_bad++; $display("FAIL burst_ptrs: rd_ptr %h level %h want 4 0", rd_ptr, level);
    end
  endtask

  task automatic test_backpressure();
    int stab0;
    do_reset();
    for (int i = 0; i < 8; i++) begin ln[i] = rnd_line(); mem[i] = ln[i]; end
    stab0 = stab_err;
    wr_ptr = 5'd8;
    repeat (10) tick();
    n_cmp++;
    if (rd_ptr !== 5'd3 || level !== 5'd5) begin
      n_bad++; $display("FAIL bp_credit: rd_ptr %h level %h want 3 5", rd_ptr, level);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== ln[0]) begin
      n_bad++; $display("FAIL bp_hold: valid %b data %h want 1 %h", out_valid, out_data, ln[0]);
    end
    n_cmp++;
    if (stab_err !== stab0) begin n_bad++; $display("FAIL bp_stable: got %0d want %0d", stab_err, stab0); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== ln[i]) begin
        n_bad++; $display("FAIL bp_drain beat %0d: valid %b data %h want 1 %h", i, out_valid, out_data, ln[i]);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || rd_ptr !== 5'd8) begin
      n_bad++; $display("FAIL bp_done: valid %b rd_ptr %h want 0 8", out_valid, rd_ptr);
    end
  endtask

  task automatic test_wrap();
    logic [AW:0]   wp;
    logic [AW:0]   diff;
    logic [DW-1:0] d;
    int            written;
    int            cyc;
    do_reset();
    got.delete(); exp_q.delete();
    wp = '0; written = 0; cyc = 0;
    while (got.size() < 21 && cyc < 600) begin
      diff = wp - rd_ptr;
      if (written < 21 && $urandom_range(0, 3) != 0 && diff < (AW+1)'(N)) begin
        d = rnd_line();
        mem[wp[AW-1:0]] = d;
        exp_q.push_back(d);
        wp = wp + 1'b1;
        wr_ptr = wp;
        written++;
      end
      out_ready = (cyc >= 24) ? cyc[0] : 1'b0;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (got.size() != 21) begin n_bad++; $display("FAIL wrap_count: got %0d want 21 (cycles %0d)", got.size(), cyc); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL wrap_beat %0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    tick();
    n_cmp++;
    if (rd_ptr !== 5'h15 || ram_addr_r !== 4'd5 || level !== '0) begin
      n_bad++; $display("FAIL wrap_ptrs: rd_ptr %h addr %h level %h want 15 5 0", rd_ptr, ram_addr_r, level);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 7; i++) begin ln[i % 8] = rnd_line(); mem[i] = ln[i % 8]; end
    got.delete();
    wr_ptr = 5'd6;
    tick(); tick();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (ram_r_en !== 1'b0) begin n_bad++; $display("FAIL flush_no_issue: got %b want 0", ram_r_en); end
    tick();
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || rd_ptr !== 5'd6 || level !== '0) begin
      n_bad++; $display("FAIL flush_state: valid %b rd_ptr %h level %h want 0 6 0", out_valid, rd_ptr, level);
    end
    repeat (6) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_quiet: valid %b want 0", out_valid); end
    out_ready = 1'b1;
    wr_ptr = 5'd7;
    repeat (8) tick();
    n_cmp++;
    if (got.size() != 1) begin
      n_bad++; $display("FAIL flush_after_count: got %0d want 1", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== ln[6]) begin n_bad++; $display("FAIL flush_after_data: got %h want %h", got[0], ln[6]); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    mem[7] = rnd_line(); mem[8] = rnd_line();
    got.delete();
    wr_ptr = 5'd9;
    repeat (5) tick();
    n_cmp++;
    if (out_valid !== 1'b1 || rd_ptr !== 5'd9) begin
      n_bad++; $display("FAIL rstmid_pre: valid %b rd_ptr %h want 1 9", out_valid, rd_ptr);
    end
    rst = 1'b1;
    wr_ptr = '0;
    #1;
    n_cmp++;
    if (ram_r_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_r_en: got %b want 0", ram_r_en); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || rd_ptr !== '0 || out_data !== '0) begin
      n_bad++; $display("FAIL rstmid_state: valid %b rd_ptr %h data %h want 0 0 0", out_valid, rd_ptr, out_data);
    end
    rst = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || got.size() != 0) begin
      n_bad++; $display("FAIL rstmid_quiet: valid %b beats %0d want 0 0", out_valid, got.size());
    end
    n_cmp++;
    if (x_err != 0 || stab_err != 0) begin
      n_bad++; $display("FAIL stream_integrity: x %0d unstable %0d want 0 0", x_err, stab_err);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    test_reset();
    test_burst4();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
